s38584_n5865_bank: RTL and testbench

- Parametrised, registered, multi-channel successor of the s38584 n5865 next-state cone.
- Evaluates NCH independent copies of the cone on per-channel 35-bit input vectors each sampled cycle, with optional g1592 state feedback and optional output pipeline stages.
- Compacts the outputs over a programmed sample window into a MISR signature for reliability-campaign golden/faulty comparison.

---
 rtl/s38584_pkg.sv | 51 +++++
 rtl/s38584_n5865_fn.sv | 41 ++++
 rtl/s38584_n5865_bank.sv | 122 ++++++++++++
 tb/tb_s38584_n5865_bank.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s38584_pkg.sv
// Shared definitions for the s38584 n5865 channel bank: FSM states and the
// bit positions of the 35 named cone inputs inside one channel's vector.
package s38584_pkg;

  localparam int IN_W = 35;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Bit index of each named signal within a channel vector, LSB first.
  localparam int G35   = 0;
  localparam int G1592 = 1;
  localparam int G112  = 2;
  localparam int G1668 = 3;
  localparam int G1636 = 4;
  localparam int G504  = 5;
  localparam int G113  = 6;
  localparam int G1075 = 7;
  localparam int G1211 = 8;
  localparam int G1205 = 9;
  localparam int G1216 = 10;
  localparam int G1221 = 11;
  localparam int G1183 = 12;
  localparam int G1135 = 13;
  localparam int G2130 = 14;
  localparam int G134  = 15;
  localparam int G99   = 16;
  localparam int G37   = 17;
  localparam int G1061 = 18;
  localparam int G1171 = 19;
  localparam int G979  = 20;
  localparam int G947  = 21;
  localparam int G2145 = 22;
  localparam int G2138 = 23;
  localparam int G482  = 24;
  localparam int G73   = 25;
  localparam int G528  = 26;
  localparam int G518  = 27;
  localparam int G72   = 28;
  localparam int G490  = 29;
  localparam int G209  = 30;
  localparam int G1193 = 31;
  localparam int G969  = 32;
  localparam int G1008 = 33;
  localparam int G691  = 34;

endpackage

// File: rtl/s38584_n5865_fn.sv
// Combinational n5865 next-state cone for a single channel; g1592 may be
// overridden by the caller's state bit when feedback is enabled.
module s38584_n5865_fn
  import s38584_pkg::*;
(
  input  logic [IN_W-1:0] vec_i,
  input  logic            fb_sel_i,
  input  logic            fb_val_i,
  output logic            f_o
);

  logic g1592;
  logic p_term;
  logic a_term;
  logic b_term;
  logic c_term;

  assign g1592 = fb_sel_i ? fb_val_i : vec_i[G1592];

  assign p_term = vec_i[G1075] &
                  ~(vec_i[G979] & ~vec_i[G1183] & vec_i[G1171] & vec_i[G1061] &
                    ~vec_i[G1221] & ~vec_i[G1216] & ~vec_i[G1205] & ~vec_i[G1211]);

  assign a_term = ~(vec_i[G2130] & ~vec_i[G2138] & ~vec_i[G2145]) &
                  (vec_i[G134] | (vec_i[G691] & ~vec_i[G209] & vec_i[G1193] &
                                  (vec_i[G1008] | vec_i[G969]))) &
                  (vec_i[G947] | ~vec_i[G1135]) &
                  ~p_term;

  assign b_term = vec_i[G112] & ~vec_i[G113] &
                  (vec_i[G134] | (vec_i[G37] & vec_i[G99])) &
                  ~vec_i[G504] & ~vec_i[G518] & ~vec_i[G528] &
                  (vec_i[G490] == vec_i[G73]) &
                  (vec_i[G72] == vec_i[G482]);

  assign c_term = (vec_i[G1636] & ~g1592) | vec_i[G1668];

  // A together with g1592 cancels the blocking effect of the A|B|C term.
  assign f_o = vec_i[G35] & ~((a_term | b_term | c_term) & ~(a_term & g1592));

endmodule

// File: rtl/s38584_n5865_bank.sv
// NCH-channel registered bank of the n5865 cone with an optional output
// pipeline and a MISR that compacts the outputs over a programmed window.
module s38584_n5865_bank
  import s38584_pkg::*;
#(
  parameter int               NCH      = 4,
  parameter int               PIPE     = 0,
  parameter int               FEEDBACK = 0,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] POLY     = 16'h1021,
  parameter logic [SIG_W-1:0] SEED     = '1,
  parameter int               CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    window,
  input  logic                in_valid,
  input  logic [NCH*IN_W-1:0] in_vec,
  output logic [NCH-1:0]      out,
  output logic                out_valid,
  output logic                busy,
  output logic                done,
  output logic [SIG_W-1:0]    signature
);

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [NCH-1:0]   d);
    logic [SIG_W-1:0] dx;
    dx          = '0;
    dx[NCH-1:0] = d;
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0) ^ dx;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SIG_W-1:0]   sig_q, sig_d;

  // Entry 0 is the per-channel state register, entries 1..PIPE the output stages.
  logic [PIPE:0][NCH-1:0] dat_q;
  logic [PIPE:0]          vld_q;

  logic [NCH-1:0] f;
  logic           accept;
  logic           stages_empty;
  logic           busy_w;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    s38584_n5865_fn u_fn (
      .vec_i    (in_vec[c*IN_W +: IN_W]),
      .fb_sel_i (FEEDBACK != 0),
      .fb_val_i (dat_q[0][c]),
      .f_o      (f[c])
    );
  end

  assign accept       = (state_q == S_RUN) && in_valid;
  assign stages_empty = ~|vld_q;
  assign busy_w       = (state_q == S_RUN) || (state_q == S_DRAIN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    if (busy_w && vld_q[PIPE]) begin
      sig_d = misr_step(sig_q, dat_q[PIPE]);
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = window;
          sig_d   = SEED;
          state_d = (window == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (stages_empty) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sig_q   <= '0;
      dat_q   <= '0;
      vld_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sig_q    <= sig_d;
      // Stage 0: state register loads only on accepted samples
      dat_q[0] <= accept ? f : dat_q[0];
      vld_q[0] <= accept;
      // Stages 1..PIPE: plain delay line carrying data and valid together
      for (int k = 1; k <= PIPE; k++) begin
        dat_q[k] <= dat_q[k-1];
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  assign out       = dat_q[PIPE];
  assign out_valid = vld_q[PIPE];
  assign busy      = busy_w;
  assign done      = (state_q == S_DONE);
  assign signature = sig_q;

endmodule

// File: tb/tb_s38584_n5865_bank.sv
// Bench for s38584_n5865_bank: three configurations share one directed
// stimulus stream and are checked every cycle against a behavioural model.
module tb_s38584_n5865_bank;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  window = '0;
  logic         in_valid = 1'b0;
  logic [139:0] in_vec = '0;

  logic [3:0]  out_a  [3];
  logic        ov_a   [3];
  logic        busy_a [3];
  logic        done_a [3];
  logic [15:0] sig_a  [3];

  int n_vec = 0;
  int n_err = 0;
  int n_done0 = 0;
  int n_ov0 = 0;
  bit cmp_en = 1'b0;

  always #5 clock = ~clock;

  // Instance 0: PIPE=0 no feedback; 1: PIPE=2 no feedback; 2: PIPE=0 feedback.
  s38584_n5865_bank #(.NCH(4), .PIPE(0), .FEEDBACK(0)) u_p0 (
    .clock(clock), .reset(reset), .start(start), .window(window),
    .in_valid(in_valid), .in_vec(in_vec), .out(out_a[0]), .out_valid(ov_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .signature(sig_a[0]));

  s38584_n5865_bank #(.NCH(4), .PIPE(2), .FEEDBACK(0)) u_p2 (
    .clock(clock), .reset(reset), .start(start), .window(window),
    .in_valid(in_valid), .in_vec(in_vec), .out(out_a[1]), .out_valid(ov_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .signature(sig_a[1]));

  s38584_n5865_bank #(.NCH(4), .PIPE(0), .FEEDBACK(1)) u_fb (
    .clock(clock), .reset(reset), .start(start), .window(window),
    .in_valid(in_valid), .in_vec(in_vec), .out(out_a[2]), .out_valid(ov_a[2]),
    .busy(busy_a[2]), .done(done_a[2]), .signature(sig_a[2]));

  task automatic chk(input string nm, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, expected %0h at %0t", nm, idx, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int pipe_of(input int i);
    return (i == 1) ? 2 : 0;
  endfunction

  function automatic logic model_f(input logic [34:0] v, input logic g1592);
    logic g35, g112, g1668, g1636, g504, g113, g1075, g1211, g1205, g1216;
    logic g1221, g1183, g1135, g2130, g134, g99, g37, g1061, g1171, g979;
    logic g947, g2145, g2138, g482, g73, g528, g518, g72, g490, g209;
    logic g1193, g969, g1008, g691, p, a, b, c;
    g35 = v[0];   g112 = v[2];   g1668 = v[3];  g1636 = v[4];  g504 = v[5];
    g113 = v[6];  g1075 = v[7];  g1211 = v[8];  g1205 = v[9];  g1216 = v[10];
    g1221 = v[11]; g1183 = v[12]; g1135 = v[13]; g2130 = v[14]; g134 = v[15];
    g99 = v[16];  g37 = v[17];   g1061 = v[18]; g1171 = v[19]; g979 = v[20];
    g947 = v[21]; g2145 = v[22]; g2138 = v[23]; g482 = v[24];  g73 = v[25];
    g528 = v[26]; g518 = v[27];  g72 = v[28];   g490 = v[29];  g209 = v[30];
    g1193 = v[31]; g969 = v[32]; g1008 = v[33]; g691 = v[34];
    p = g1075 & ~(g979 & ~g1183 & g1171 & g1061 & ~g1221 & ~g1216 & ~g1205 & ~g1211);
    a = ~(g2130 & ~g2138 & ~g2145) & (g134 | (g691 & ~g209 & g1193 & (g1008 | g969)))
        & (g947 | ~g1135) & ~p;
    b = g112 & ~g113 & (g134 | (g37 & g99)) & ~g504 & ~g518 & ~g528
        & (g490 == g73) & (g72 == g482);
    c = (g1636 & ~g1592) | g1668;
    return g35 & ~((a | b | c) & ~(a & g1592));
  endfunction

  function automatic logic [15:0] model_misr(input logic [15:0] s, input logic [3:0] d);
    logic [15:0] r;
    r = s << 1;
    if (s[15]) r = r ^ 16'h1021;
    return r ^ {12'b0, d};
  endfunction

  // Phase: 0 idle, 1 accepting, 2 draining, 3 done pulse.
  int          ph    [3];
  int          left  [3];
  logic [3:0]  mst   [3];
  logic [15:0] msig  [3];
  int          due_r [3][8];
  logic [3:0]  val_r [3][8];
  int          head  [3];
  int          tail  [3];
  int          mcyc = 0;

  task automatic model_step(input int i);
    bit         inflight;
    bit         mbusy;
    logic [3:0] nv;
    if (reset) begin
      ph[i] = 0; left[i] = 0; mst[i] = '0; msig[i] = '0; head[i] = 0; tail[i] = 0;
      return;
    end
    mbusy    = (ph[i] == 1) || (ph[i] == 2);
    inflight = tail[i] > head[i];
    if (inflight && due_r[i][head[i] % 8] == mcyc) begin
      if (mbusy) msig[i] = model_misr(msig[i], val_r[i][head[i] % 8]);
      head[i]++;
    end
    case (ph[i])
      0: if (start) begin
        msig[i] = 16'hFFFF;
        left[i] = int'(window);
        ph[i]   = (window == 0) ? 2 : 1;
      end
      1: if (in_valid) begin
        for (int c = 0; c < 4; c++)
          nv[c] = model_f(in_vec[35*c +: 35], (i == 2) ? mst[i][c] : in_vec[35*c+1]);
        mst[i] = nv;
        due_r[i][tail[i] % 8] = mcyc + 1 + pipe_of(i);
        val_r[i][tail[i] % 8] = nv;
        tail[i]++;
        left[i]--;
        if (left[i] == 0) ph[i] = 2;
      end
      2: if (!inflight) ph[i] = 3;
      default: ph[i] = 0;
    endcase
  endtask

  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) model_step(i);
    if (reset) cmp_en = 1'b1;
    mcyc++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        bit exp_ov;
        exp_ov = (tail[i] > head[i]) && (due_r[i][head[i] % 8] == mcyc);
        chk("out_valid", i, ov_a[i], exp_ov);
        chk("busy", i, busy_a[i], (ph[i] == 1) || (ph[i] == 2));
        chk("done", i, done_a[i], ph[i] == 3);
        chk("signature", i, sig_a[i], msig[i]);
        if (exp_ov) chk("out", i, out_a[i], val_r[i][head[i] % 8]);
      end
      if (done_a[0]) n_done0++;
      if (ov_a[0]) n_ov0++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_start(input int w);
    start  = 1'b1;
    window = w[15:0];
    tick();
    start  = 1'b0;
  endtask

  task automatic sample(input logic [34:0] v3, input logic [34:0] v2,
                        input logic [34:0] v1, input logic [34:0] v0);
    in_valid = 1'b1;
    in_vec   = {v3, v2, v1, v0};
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 40; k++) begin
      if (!busy_a[0] && !busy_a[1] && !busy_a[2] &&
          !done_a[0] && !done_a[1] && !done_a[2]) break;
      tick();
    end
    chk("idle_timeout", 0, k < 40, 1);
  endtask

  task automatic chk_all_zero(input string nm);
    for (int i = 0; i < 3; i++) begin
      chk({nm, "_out"}, i, out_a[i], 0);
      chk({nm, "_ovld"}, i, ov_a[i], 0);
      chk({nm, "_busy"}, i, busy_a[i], 0);
      chk({nm, "_done"}, i, done_a[i], 0);
      chk({nm, "_sig"}, i, sig_a[i], 0);
    end
  endtask

  logic [34:0] tv [8][4];
  logic        tvld [8];
  logic        tst  [8];

  initial begin
    int d0, o0, lat, k;
    tick(); tick(); tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // Cone truth: channels 3..0 expect 1,0,0,1.
    do_start(1);
    sample(35'h1, 35'h0, 35'h9, 35'h3);
    chk("cone_ovld", 0, ov_a[0], 1);
    chk("cone_out", 0, out_a[0], 4'b1001);
    wait_idle();

    // MISR over one all-zero sample from the all-ones seed.
    d0 = n_done0;
    do_start(1);
    sample(35'h0, 35'h0, 35'h0, 35'h0);
    wait_idle();
    chk("misr_sig", 0, sig_a[0], 16'hEFDF);
    chk("misr_sig", 1, sig_a[1], 16'hEFDF);
    chk("misr_sig", 2, sig_a[2], 16'hEFDF);
    chk("misr_done_pulses", 0, n_done0 - d0, 1);

    // Latency with PIPE=2: three edges from driving in_valid to out_valid.
    do_start(1);
    chk("lat_busy_start", 1, busy_a[1], 1);
    in_valid = 1'b1;
    in_vec   = '0;
    lat = 0;
    for (k = 0; k < 6; k++) begin
      tick();
      in_valid = 1'b0;
      lat++;
      if (ov_a[1]) break;
    end
    chk("lat_edges", 1, lat, 3);
    chk("lat_busy_out", 1, busy_a[1], 1);
    wait_idle();

    // Feedback: st=1 masks g1636 on the second sample.
    do_start(2);
    sample(35'h1, 35'h1, 35'h1, 35'h1);
    chk("fb_first", 2, out_a[2], 4'hF);
    chk("fb_first", 0, out_a[0], 4'hF);
    sample(35'h11, 35'h11, 35'h11, 35'h11);
    chk("fb_second", 2, out_a[2], 4'hF);
    chk("fb_second", 0, out_a[0], 4'h0);
    wait_idle();

    // Window of 3 with gaps, stray starts and trailing in_valid.
    tv[0] = '{35'h8005, 35'h8007, 35'h8087, 35'h4_0000_0001};
    tv[1] = '{35'h1, 35'h3, 35'h9, 35'h11};
    tv[2] = '{35'h7, 35'h8005, 35'h0, 35'h1};
    tv[3] = '{35'h8007, 35'h1, 35'h11, 35'h8087};
    tv[4] = '{35'h3, 35'h3, 35'h3, 35'h3};
    tv[5] = '{35'h8005, 35'h11, 35'h1, 35'h9};
    tv[6] = '{35'h1, 35'h1, 35'h1, 35'h1};
    tv[7] = '{35'h9, 35'h9, 35'h9, 35'h9};
    tvld = '{1, 0, 0, 1, 0, 1, 1, 1};
    tst  = '{0, 0, 1, 0, 0, 1, 0, 0};
    o0 = n_ov0;
    do_start(3);
    for (int j = 0; j < 8; j++) begin
      in_valid = tvld[j];
      start    = tst[j];
      window   = 16'd5;
      in_vec   = {tv[j][0], tv[j][1], tv[j][2], tv[j][3]};
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b0;
    wait_idle();
    chk("w3_samples", 0, n_ov0 - o0, 3);

    // Empty window finishes quickly with the untouched seed.
    do_start(0);
    for (k = 0; k < 3; k++) begin
      if (done_a[0]) break;
      tick();
    end
    chk("w0_done_within3", 0, k < 3, 1);
    chk("w0_sig", 0, sig_a[0], 16'hFFFF);
    wait_idle();

    // Reset after one of four samples, then a clean restart.
    do_start(4);
    sample(35'h1, 35'h1, 35'h1, 35'h1);
    reset = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all_zero("midreset");
    reset = 1'b0;
    tick();
    do_start(1);
    sample(35'h0, 35'h0, 35'h0, 35'h0);
    wait_idle();
    chk("restart_sig", 0, sig_a[0], 16'hEFDF);
    chk("restart_sig", 1, sig_a[1], 16'hEFDF);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
